// File: rtl/serial_sub_if.sv
// serial_sub_if: operand/result valid-ready bus plus serial probe for the bit-serial subtractor
interface serial_sub_if #(parameter int WIDTH = 8);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             diff_bit;
  logic             diff_bit_valid;
  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, bout, diff_bit, diff_bit_valid
  );
  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, bout, diff_bit, diff_bit_valid
  );
endinterface

// File: rtl/serial_sub_unit.sv
// serial_sub_unit: bit-serial ripple subtractor, one bit per clock LSB first through a single borrow flop
module serial_sub_unit #(
  parameter int WIDTH = 8
) (
  input logic clk,
  input logic rst,
  serial_sub_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             brw;
  logic [CW-1:0]    cnt;
  logic             x;
  logic             y;
  logic             d;
  logic             nb;
  logic [WIDTH:0]   cat;
  assign x   = a_sh[0];
  assign y   = b_sh[0];
  assign d   = x ^ y ^ brw;
  assign nb  = (~x & y) | (~(x ^ y) & brw);
  // new bit enters at the MSB; slicing the concatenation keeps WIDTH=1 legal
  assign cat = {d, bus.diff};
  assign bus.diff_bit       = (state == RUN) & d;
  assign bus.diff_bit_valid = state == RUN;
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.diff      <= '0;
      bus.bout      <= 1'b0;
      a_sh          <= '0;
      b_sh          <= '0;
      brw           <= 1'b0;
      cnt           <= '0;
    end else if (state == IDLE) begin
      if (bus.in_valid) begin
        a_sh         <= bus.a;
        b_sh         <= bus.b;
        brw          <= bus.bin;
        cnt          <= '0;
        bus.in_ready <= 1'b0;
        state        <= RUN;
      end
    end else if (state == RUN) begin
      brw      <= nb;
      bus.diff <= cat[WIDTH:1];
      a_sh     <= a_sh >> 1;
      b_sh     <= b_sh >> 1;
      cnt      <= cnt + CW'(1);
      if (cnt == CW'(WIDTH - 1)) begin
        bus.out_valid <= 1'b1;
        bus.bout      <= nb;
        state         <= DONE;
      end
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
      bus.in_ready  <= 1'b1;
      state         <= IDLE;
    end
  end
endmodule

// File: tb/tb_serial_sub_unit.sv
// tb_serial_sub_unit: directed checks of the serial subtractor at WIDTH=8 and WIDTH=1
module tb_serial_sub_unit;
  logic clk;
  logic rst;
  int   errors;
  int   checks;
  int   lat;
  int   nbits;
  logic [7:0] stream;
  serial_sub_if #(.WIDTH(8)) u8 ();
  serial_sub_if #(.WIDTH(1)) u1 ();
  serial_sub_unit #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(u8));
  serial_sub_unit #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(u1));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic accept(input logic [7:0] a, input logic [7:0] b, input logic bin);
    u8.a = a;
    u8.b = b;
    u8.bin = bin;
    u8.in_valid = 1'b1;
    step();
    u8.in_valid = 1'b0;
  endtask
  // lat counts clock edges from the accept edge (inclusive) until out_valid is seen
  task automatic wait_out(output int l, output logic [7:0] s, output int n);
    l = 1;
    n = 0;
    s = '0;
    while (!u8.out_valid && l < 40) begin
      if (u8.diff_bit_valid) begin
        if (n < 8) s[n] = u8.diff_bit;
        n++;
      end
      step();
      l++;
    end
  endtask
  task automatic release_out;
    u8.out_ready = 1'b1;
    step();
    u8.out_ready = 1'b0;
  endtask
  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    {u8.in_valid, u8.a, u8.b, u8.bin, u8.out_ready} = '0;
    {u1.in_valid, u1.a, u1.b, u1.bin, u1.out_ready} = '0;
    step();
    step();
    rst = 1'b0;
    step();
    chk("rst_in_ready", u8.in_ready, 1);
    chk("rst_out_valid", u8.out_valid, 0);
    chk("rst_diff", u8.diff, 0);
    chk("rst_bout", u8.bout, 0);
    chk("rst_diff_bit", u8.diff_bit, 0);
    chk("rst_diff_bit_valid", u8.diff_bit_valid, 0);
    u8.out_ready = 1'b1;
    step();
    u8.out_ready = 1'b0;
    chk("idle_out_ready_valid", u8.out_valid, 0);
    chk("idle_out_ready_ready", u8.in_ready, 1);
    // 5 - 3 - 0
    accept(8'h05, 8'h03, 1'b0);
    chk("t1_in_ready_run", u8.in_ready, 0);
    wait_out(lat, stream, nbits);
    chk("t1_latency", lat, 9);
    chk("t1_diff", u8.diff, 8'h02);
    chk("t1_bout", u8.bout, 0);
    chk("t1_nbits", nbits, 8);
    chk("t1_stream", stream, 8'h02);
    chk("t1_bit_valid_done", u8.diff_bit_valid, 0);
    release_out();
    chk("t1_out_valid_cleared", u8.out_valid, 0);
    chk("t1_in_ready_back", u8.in_ready, 1);
    // 0 - 1 wraps
    accept(8'h00, 8'h01, 1'b0);
    wait_out(lat, stream, nbits);
    chk("t2_diff", u8.diff, 8'hFF);
    chk("t2_bout", u8.bout, 1);
    chk("t2_nbits", nbits, 8);
    chk("t2_stream", stream, 8'hFF);
    release_out();
    // 0x80 - 0x7F - 1, then stall
    accept(8'h80, 8'h7F, 1'b1);
    wait_out(lat, stream, nbits);
    for (int i = 0; i < 5; i++) begin
      chk("t3_stall_valid", u8.out_valid, 1);
      chk("t3_stall_diff", u8.diff, 8'h00);
      chk("t3_stall_bout", u8.bout, 0);
      step();
    end
    release_out();
    // reset during the 4th RUN cycle
    accept(8'hAA, 8'h55, 1'b0);
    step();
    step();
    step();
    chk("t4_still_run", u8.diff_bit_valid, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t4_out_valid", u8.out_valid, 0);
    chk("t4_diff", u8.diff, 0);
    chk("t4_in_ready", u8.in_ready, 1);
    chk("t4_bit_valid", u8.diff_bit_valid, 0);
    accept(8'h10, 8'h01, 1'b0);
    wait_out(lat, stream, nbits);
    chk("t4_latency", lat, 9);
    chk("t4_diff_fresh", u8.diff, 8'h0F);
    chk("t4_bout_fresh", u8.bout, 0);
    release_out();
    // second operand set held during RUN/DONE must wait for IDLE
    accept(8'h30, 8'h10, 1'b0);
    u8.a = 8'hFF;
    u8.b = 8'h01;
    u8.bin = 1'b1;
    u8.in_valid = 1'b1;
    wait_out(lat, stream, nbits);
    chk("t5_diff_first", u8.diff, 8'h20);
    chk("t5_bout_first", u8.bout, 0);
    chk("t5_in_ready_done", u8.in_ready, 0);
    step();
    chk("t5_hold_done", u8.out_valid, 1);
    release_out();
    chk("t5_idle_ready", u8.in_ready, 1);
    step();
    u8.in_valid = 1'b0;
    chk("t5_second_accepted", u8.in_ready, 0);
    wait_out(lat, stream, nbits);
    chk("t5_diff_second", u8.diff, 8'hFD);
    chk("t5_bout_second", u8.bout, 0);
    release_out();
    // WIDTH=1 exhaustive, expectations from integer arithmetic
    for (int i = 0; i < 8; i++) begin
      int e;
      logic [2:0] v;
      v = 3'(i);
      e = int'(v[2]) - int'(v[1]) - int'(v[0]);
      u1.a = v[2];
      u1.b = v[1];
      u1.bin = v[0];
      u1.in_valid = 1'b1;
      step();
      u1.in_valid = 1'b0;
      lat = 1;
      while (!u1.out_valid && lat < 10) begin
        step();
        lat++;
      end
      chk("w1_latency", lat, 2);
      chk("w1_diff", u1.diff, e & 1);
      chk("w1_bout", u1.bout, e < 0);
      u1.out_ready = 1'b1;
      step();
      u1.out_ready = 1'b0;
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
